// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU-facing UART controller.
// Synchronizes the receiver/transmitter status levels into the system clock, queues received
// bytes in a small FIFO, and feeds the transmitter through a one-byte holding register and a
// level handshake (TX_EN request, TX_STATUS idle/busy).
// Ports:
//   clk_i, reset_i        system clock, synchronous active-high reset
//   sel_i, wr_i, addr_i   bus access strobe, write/read, register select
//                         (0 RXD, 1 TXD, 2 STATUS, 3 CTRL)
//   wdata_i, rdata_o      write data, registered read data
//   irq_o                 registered level interrupt
//   rx_data_i, rx_status_i  received byte and receiver done level (async)
//   tx_data_o, tx_en_o      byte and request level to the transmitter
//   tx_status_i             transmitter idle level (async)
module uart_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sel_i,
    input  logic       wr_i,
    input  logic [1:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       irq_o,
    input  logic [7:0] rx_data_i,
    input  logic       rx_status_i,
    output logic [7:0] tx_data_o,
    output logic       tx_en_o,
    input  logic       tx_status_i
);

    localparam logic [1:0] AddrRxd    = 2'd0;
    localparam logic [1:0] AddrTxd    = 2'd1;
    localparam logic [1:0] AddrStatus = 2'd2;
    localparam logic [1:0] AddrCtrl   = 2'd3;
    localparam logic [PTR_W:0] CntFull = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {StIdle, StStart, StBusy} tx_state_e;

    logic             rx_s1_q, rx_s2_q, rx_hist_q;
    logic             tx_s1_q, tx_s2_q;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovr_q, ovr_d;
    logic             rx_ie_q, tx_ie_q;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    tx_state_e        state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             irq_q;

    logic rd_acc, wr_acc, rx_empty, rx_full, push, pop, push_ok;
    logic [7:0] status;

    assign rd_acc   = sel_i & ~wr_i;
    assign wr_acc   = sel_i & wr_i;
    assign rx_empty = (count_q == '0);
    assign rx_full  = (count_q == CntFull);
    assign push     = rx_s2_q & ~rx_hist_q;
    assign pop      = rd_acc & (addr_i == AddrRxd) & ~rx_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push & (~rx_full | pop);
    assign status   = {3'b000, state_q != StIdle, ~hold_full_q, ovr_q, rx_full, ~rx_empty};

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (wr_acc && addr_i == AddrStatus && wdata_i[2]) begin
            ovr_d = 1'b0;
        end
        // A dropped byte in the same cycle beats the clear.
        if (push && rx_full && !pop) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) begin
            case (addr_i)
                AddrRxd:    rdata_d = rx_empty ? 8'h00 : fifo_q[rptr_q];
                AddrTxd:    rdata_d = 8'h00;
                AddrStatus: rdata_d = status;
                default:    rdata_d = {6'b000000, tx_ie_q, rx_ie_q};
            endcase
        end
    end

    // TX sequencing: IDLE waits for a held byte and an idle transmitter, START raises the request
    // until the transmitter goes busy, BUSY waits for it to return idle.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        unique case (state_q)
            StIdle: begin
                if (hold_full_q && tx_s2_q) begin
                    tx_data_d   = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = StStart;
                end
            end
            StStart: if (!tx_s2_q) state_d = StBusy;
            StBusy:  if (tx_s2_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (wr_acc && addr_i == AddrTxd && !hold_full_q) begin
            hold_d      = wdata_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Sync chain resets to idle-high so leaving reset never looks like an edge.
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_hist_q   <= 1'b1;
            tx_s1_q     <= 1'b1;
            tx_s2_q     <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ovr_q       <= 1'b0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            state_q     <= StIdle;
            tx_data_q   <= 8'h00;
            rdata_q     <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            rx_s1_q     <= rx_status_i;
            rx_s2_q     <= rx_s1_q;
            rx_hist_q   <= rx_s2_q;
            tx_s1_q     <= tx_status_i;
            tx_s2_q     <= tx_s1_q;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q     <= count_d;
            ovr_q       <= ovr_d;
            if (wr_acc && addr_i == AddrCtrl) begin
                rx_ie_q <= wdata_i[0];
                tx_ie_q <= wdata_i[1];
            end
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            rdata_q     <= rdata_d;
            irq_q       <= (rx_ie_q & ~rx_empty) | (tx_ie_q & ~hold_full_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_q[wptr_q] <= rx_data_i;
    end

    assign rdata_o   = rdata_q;
    assign irq_o     = irq_q;
    assign tx_data_o = tx_data_q;
    assign tx_en_o   = (state_q == StStart);

endmodule
